float_addsub_scheduler: RTL and testbench
=========================================

Name: float_addsub_scheduler

Overview:
- Round-robin scheduler that shares one pipelined floating-point adder between NUM_REQ requesters.
- Each requester issues add or subtract operations over a valid/ready handshake.
- The block drives the shared adder's ce and operand ports and tracks in-flight ops in a tag pipeline aligned to the adder latency.
- Results are returned on a single result port tagged with the requester id, with backpressure that freezes the adder.

Parameters:
MANTISSA_SIZE, 23, mantissa width of the float format
EXPONENT_SIZE, 8, exponent width
NUM_REQ, 4, number of requesters (2..16)
ADD_LATENCY, 4, adder latency in ce-enabled cycles (fixed at 4 for the current adder)
(localparams) FLOAT_SIZE = 1+EXPONENT_SIZE+MANTISSA_SIZE; ID_SIZE = max(1, clog2(NUM_REQ)); SIGN_POS = FLOAT_SIZE-1

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
reqValid  in  NUM_REQ  per-requester operation valid
reqSub  in  NUM_REQ  1 = a-b, 0 = a+b
reqA  in  NUM_REQ*FLOAT_SIZE  operand a; requester i occupies slice i
reqB  in  NUM_REQ*FLOAT_SIZE  operand b; requester i occupies slice i
reqReady  out  NUM_REQ  one-hot grant; the handshake completes on reqValid[i]&reqReady[i]
addCe  out  1  ce to the shared adder
addA  out  FLOAT_SIZE  adder operand a
addB  out  FLOAT_SIZE  adder operand b (sign already flipped for subtract)
addSum  in  FLOAT_SIZE  adder result
resValid  out  1  result valid
resId  out  ID_SIZE  requester id of the result
result  out  FLOAT_SIZE  result value (= addSum)
resReady  in  1  result consumer ready

Behaviour:
- Stall: stall = resValid & ~resReady.
- addCe = ~stall (combinational). While stalled, the adder, the tag pipeline and the rr pointer all hold.
- Arbitration (combinational):
  - Only when addCe = 1.
  - Winner = first i with reqValid[i] set, searching from (ptr+1) mod NUM_REQ upward with wrap.
  - reqReady = onehot(winner); all zero if no requester is valid or the block is stalled.
  - reqReady never depends on the requester's own reqValid beyond the search.
- Operand mux:
  - addA = reqA[winner].
  - addB = reqB[winner], with bit SIGN_POS inverted when reqSub[winner] = 1.
  - With no winner, addA/addB are don't-care (drive zero).
- Pointer:
  - On an accepted grant with addCe = 1, ptr <= winner.
  - Reset value NUM_REQ-1, so requester 0 wins first after reset.
- Tag pipeline:
  - ADD_LATENCY stages of {valid, id}, advanced only when addCe = 1.
  - Stage 0 input: {grant_any, winner}.
  - resValid/resId = last stage. result = addSum, combinational passthrough.
- Latency and throughput:
  - An op accepted in cycle t with no stalls appears with resValid = 1 in cycle t+ADD_LATENCY.
  - Throughput is 1 op/cycle.
- Result handshake:
  - The result is consumed when resValid & resReady.
  - While resValid & ~resReady: resValid, resId and result hold stable (the adder is frozen by ce) and no grants are issued.
  - resReady is ignored when resValid = 0; bubbles always advance.
- Reset (asynchronous, any time including mid-operation):
  - All tag valids cleared, ptr = NUM_REQ-1.
  - resValid = 0, resId = 0, reqReady = 0 while reset is asserted.
  - In-flight operations are discarded; stale addSum values never produce resValid.
- Simultaneous events: a grant and a result consumption in the same cycle are both allowed. The pipeline shifts and the new op enters stage 0.
- The adder's own special-value behaviour (inf/NaN/denormal) passes through unchanged.

Test Plan:
- Single op: requester 0 sends reqA = 0x3F800000 (1.0), reqB = 0x40000000 (2.0), sub = 0, resReady = 1 -> reqReady[0] = 1 at cycle t; resValid = 1, resId = 0, result = 0x40400000 at t+4.
- Subtract: requester 2 sends 3.0 - 1.0 (0x40400000, 0x3F800000, sub = 1) -> addB = 0xBF800000 at grant; result = 0x40000000, resId = 2 four cycles later.
- Fairness: all 4 requesters hold reqValid = 1 continuously -> grant order 0,1,2,3,0,1,…; resId follows the same order, one result per cycle after the first 4 cycles.
- Backpressure: stream 6 ops, hold resReady = 0 for 3 cycles after the first resValid -> addCe = 0 and reqReady = 0 for those 3 cycles; resValid/result/resId are stable; all 6 results are delivered in order with no loss or duplication.
- Back-to-back single requester: requester 1 issues 8 consecutive ops (k.0 + 1.0 for k = 1..8) -> 8 consecutive resValid cycles, results 2.0..9.0, all resId = 1.
- Reset mid-flight: assert reset 2 cycles after issuing 3 ops, release after 1 cycle -> resValid stays 0 until a new op is granted; the next grant goes to requester 0 if it is valid.

Source files
------------

// File: rtl/float_addsub_scheduler.sv
// Round-robin scheduler sharing one pipelined float adder between NUM_REQ requesters.
// A {valid, id} tag pipeline tracks in-flight ops; result backpressure freezes adder, tags and pointer.
module float_addsub_scheduler #(
   parameter int  MANTISSA_SIZE = 23,
   parameter int  EXPONENT_SIZE = 8,
   parameter int  NUM_REQ       = 4,
   parameter int  ADD_LATENCY   = 4,
   localparam int FLOAT_SIZE    = 1 + EXPONENT_SIZE + MANTISSA_SIZE,
   localparam int ID_SIZE       = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1,
   localparam int SIGN_POS      = FLOAT_SIZE - 1
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_REQ-1:0]            reqValid,
   input  logic [NUM_REQ-1:0]            reqSub,
   input  logic [NUM_REQ*FLOAT_SIZE-1:0] reqA,
   input  logic [NUM_REQ*FLOAT_SIZE-1:0] reqB,
   output logic [NUM_REQ-1:0]            reqReady,
   output logic                          addCe,
   output logic [FLOAT_SIZE-1:0]         addA,
   output logic [FLOAT_SIZE-1:0]         addB,
   input  logic [FLOAT_SIZE-1:0]         addSum,
   output logic                          resValid,
   output logic [ID_SIZE-1:0]            resId,
   output logic [FLOAT_SIZE-1:0]         result,
   input  logic                          resReady
);

   logic [ADD_LATENCY-1:0] vld_q, vld_d;
   logic [ID_SIZE-1:0]     id_q [ADD_LATENCY];
   logic [ID_SIZE-1:0]     id_d [ADD_LATENCY];
   logic [ID_SIZE-1:0]     ptr_q, ptr_d;
   logic                   stall;
   logic                   grant_any;
   logic [ID_SIZE-1:0]     winner;

   assign resValid = vld_q[ADD_LATENCY-1];
   assign resId    = id_q[ADD_LATENCY-1];
   assign result   = addSum;
   assign stall    = resValid & ~resReady;
   assign addCe    = ~stall;

   // Search starts one past the last winner so every valid requester is served in turn.
   always_comb begin : arbiter
      int idx;
      grant_any = 1'b0;
      winner    = '0;
      idx       = 0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = (int'(ptr_q) + k) % NUM_REQ;
         if (!grant_any && reqValid[idx]) begin
            grant_any = 1'b1;
            winner    = ID_SIZE'(idx);
         end
      end
      if (stall || reset) begin
         grant_any = 1'b0;
      end
   end

   always_comb begin : operand_mux
      reqReady = '0;
      addA     = '0;
      addB     = '0;
      if (grant_any) begin
         reqReady[winner] = 1'b1;
         addA             = reqA[int'(winner)*FLOAT_SIZE +: FLOAT_SIZE];
         addB             = reqB[int'(winner)*FLOAT_SIZE +: FLOAT_SIZE];
         addB[SIGN_POS]   = addB[SIGN_POS] ^ reqSub[winner];
      end
   end

   always_comb begin : next_state
      vld_d = vld_q;
      ptr_d = ptr_q;
      for (int k = 0; k < ADD_LATENCY; k++) begin
         id_d[k] = id_q[k];
      end
      if (addCe) begin
         vld_d[0] = grant_any;
         id_d[0]  = winner;
         for (int k = 1; k < ADD_LATENCY; k++) begin
            vld_d[k] = vld_q[k-1];
            id_d[k]  = id_q[k-1];
         end
      end
      if (grant_any) begin
         ptr_d = winner;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vld_q <= '0;
         ptr_q <= ID_SIZE'(NUM_REQ - 1);
         for (int k = 0; k < ADD_LATENCY; k++) begin
            id_q[k] <= '0;
         end
      end else begin
         vld_q <= vld_d;
         ptr_q <= ptr_d;
         for (int k = 0; k < ADD_LATENCY; k++) begin
            id_q[k] <= id_d[k];
         end
      end
   end

endmodule

// File: tb/tb_float_addsub_scheduler.sv
// Bench for float_addsub_scheduler: integer-valued float ops, a 4-stage adder model,
// and a scoreboard queue checked by a monitor on the falling edge.
module tb_float_addsub_scheduler;

   localparam int NUM_REQ = 4;
   localparam int FS      = 32;
   localparam int LAT     = 4;
   localparam int IDW     = 2;

   typedef struct {
      int a;
      int b;
      bit sub;
   } op_t;

   typedef struct {
      logic [IDW-1:0] id;
      logic [FS-1:0]  val;
      int unsigned    due;
   } exp_t;

   logic                 clk = 1'b0;
   logic                 reset;
   logic [NUM_REQ-1:0]   reqValid;
   logic [NUM_REQ-1:0]   reqSub;
   logic [NUM_REQ*FS-1:0] reqA;
   logic [NUM_REQ*FS-1:0] reqB;
   logic [NUM_REQ-1:0]   reqReady;
   logic                 addCe;
   logic [FS-1:0]        addA;
   logic [FS-1:0]        addB;
   logic [FS-1:0]        addSum;
   logic                 resValid;
   logic [IDW-1:0]       resId;
   logic [FS-1:0]        result;
   logic                 resReady;

   op_t         op_q [NUM_REQ][$];
   op_t         cur_op [NUM_REQ];
   exp_t        exp_q [$];
   bit [NUM_REQ-1:0] fire;
   int          errors = 0;
   int          checks = 0;
   int          rr_mode;
   int          ptr_m;
   int unsigned ce_cnt = 0;
   bit          prev_stall = 1'b0;
   logic [FS-1:0]  prev_res;
   logic [IDW-1:0] prev_id;
   logic [FS-1:0]  apipe [LAT] = '{default: '0};

   float_addsub_scheduler #(
      .MANTISSA_SIZE(23),
      .EXPONENT_SIZE(8),
      .NUM_REQ(NUM_REQ),
      .ADD_LATENCY(LAT)
   ) dut (
      .clk(clk),
      .reset(reset),
      .reqValid(reqValid),
      .reqSub(reqSub),
      .reqA(reqA),
      .reqB(reqB),
      .reqReady(reqReady),
      .addCe(addCe),
      .addA(addA),
      .addB(addB),
      .addSum(addSum),
      .resValid(resValid),
      .resId(resId),
      .result(result),
      .resReady(resReady)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] enc(int v);
      int mag;
      int p;
      logic [31:0] r;
      if (v == 0) return 32'h0;
      mag = (v < 0) ? -v : v;
      p = 0;
      for (int k = 0; k < 31; k++) begin
         if ((mag >> k) != 0) p = k;
      end
      r[31]    = (v < 0);
      r[30:23] = 8'(127 + p);
      r[22:0]  = 23'((mag << (23 - p)) & 32'h007F_FFFF);
      return r;
   endfunction

   function automatic int dec(logic [31:0] x);
      int p;
      int mag;
      if (x[30:23] == 8'd0) return 0;
      p = int'(x[30:23]) - 127;
      if (p < 0) p = 0;
      if (p > 23) p = 23;
      mag = int'({9'd1, x[22:0]}) >> (23 - p);
      return x[31] ? -mag : mag;
   endfunction

   // Shared adder model: LAT stages, advancing only on ce.
   always @(posedge clk) begin
      if (addCe === 1'b1) begin
         apipe[0] <= enc(dec(addA) + dec(addB));
         for (int k = 1; k < LAT; k++) apipe[k] <= apipe[k-1];
      end
   end
   assign addSum = apipe[LAT-1];

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push(int r, int a, int b, bit sub);
      op_t o;
      o.a = a;
      o.b = b;
      o.sub = sub;
      op_q[r].push_back(o);
   endtask

   task automatic push_rand(int r);
      push(r, int'($urandom_range(0, 1000)) - 500, int'($urandom_range(0, 1000)) - 500,
           bit'($urandom_range(0, 1)));
   endtask

   function automatic bit idle();
      for (int i = 0; i < NUM_REQ; i++) begin
         if (op_q[i].size() != 0) return 1'b0;
      end
      return (reqValid == '0) && (exp_q.size() == 0);
   endfunction

   task automatic wait_idle(int budget);
      int n;
      n = 0;
      while (!idle() && n < budget) begin
         @(posedge clk);
         #2;
         n++;
      end
      chk("idle_within_budget", 64'(idle()), 64'd1);
   endtask

   // Driver: each requester holds its op until the handshake, then loads the next one.
   initial begin
      reqValid = '0;
      reqSub   = '0;
      reqA     = '0;
      reqB     = '0;
      forever begin
         @(posedge clk);
         #1;
         if (reset) begin
            reqValid = '0;
            fire     = '0;
            for (int i = 0; i < NUM_REQ; i++) op_q[i].delete();
         end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
               if (fire[i]) begin
                  reqValid[i] = 1'b0;
                  fire[i]     = 1'b0;
               end
               if (!reqValid[i] && op_q[i].size() > 0) begin
                  cur_op[i]         = op_q[i].pop_front();
                  reqA[i*FS +: FS]  = enc(cur_op[i].a);
                  reqB[i*FS +: FS]  = enc(cur_op[i].b);
                  reqSub[i]         = cur_op[i].sub;
                  reqValid[i]       = 1'b1;
               end
            end
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rr_mode == 0) resReady = 1'b1;
         else if (rr_mode == 1) resReady = ($urandom_range(0, 3) != 0);
      end
   end

   // Monitor: reference arbiter, grant-time scoreboard push, result pop and compare.
   always @(negedge clk) begin
      bit stall;
      int win;
      int idx;
      logic [NUM_REQ-1:0] exp_ready;
      exp_t e;
      logic [FS-1:0] exp_b;
      if (reset) begin
         chk("reset_resValid", 64'(resValid), 64'd0);
         chk("reset_resId", 64'(resId), 64'd0);
         chk("reset_reqReady", 64'(reqReady), 64'd0);
         exp_q.delete();
         ptr_m = NUM_REQ - 1;
         prev_stall = 1'b0;
      end else begin
         stall = (resValid === 1'b1) && !resReady;
         if (prev_stall) begin
            chk("hold_resValid", 64'(resValid), 64'd1);
            chk("hold_result", 64'(result), 64'(prev_res));
            chk("hold_resId", 64'(resId), 64'(prev_id));
         end
         chk("addCe", 64'(addCe), 64'(!stall));
         win = -1;
         if (!stall) begin
            for (int k = 1; k <= NUM_REQ; k++) begin
               idx = (ptr_m + k) % NUM_REQ;
               if (win < 0 && reqValid[idx]) win = idx;
            end
         end
         exp_ready = '0;
         if (win >= 0) exp_ready[win] = 1'b1;
         chk("reqReady", 64'(reqReady), 64'(exp_ready));
         if (resValid === 1'b1) begin
            if (exp_q.size() == 0) begin
               chk("spurious_resValid", 64'(resValid), 64'd0);
            end else begin
               chk("resId", 64'(resId), 64'(exp_q[0].id));
               chk("result", 64'(result), 64'(exp_q[0].val));
               chk("latency", 64'(ce_cnt), 64'(exp_q[0].due));
               if (resReady) void'(exp_q.pop_front());
            end
         end else if (exp_q.size() > 0 && ce_cnt >= exp_q[0].due) begin
            chk("missing_result", 64'(resValid), 64'd1);
            void'(exp_q.pop_front());
         end
         if (win >= 0) begin
            exp_b = enc(cur_op[win].b);
            exp_b[31] = exp_b[31] ^ cur_op[win].sub;
            chk("addA", 64'(addA), 64'(enc(cur_op[win].a)));
            chk("addB", 64'(addB), 64'(exp_b));
            e.id  = IDW'(win);
            e.val = enc(cur_op[win].sub ? cur_op[win].a - cur_op[win].b
                                        : cur_op[win].a + cur_op[win].b);
            e.due = ce_cnt + LAT;
            exp_q.push_back(e);
            ptr_m = win;
            fire[win] = 1'b1;
         end
         if (!stall) ce_cnt++;
         prev_stall = stall;
         prev_res   = result;
         prev_id    = resId;
      end
   end

   initial begin
      int n;
      rr_mode  = 0;
      resReady = 1'b1;
      reset    = 1'b1;
      repeat (3) @(posedge clk);
      #2 reset = 1'b0;

      push(0, 1, 2, 1'b0);
      wait_idle(50);
      push(2, 3, 1, 1'b1);
      wait_idle(50);

      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < NUM_REQ; i++) push_rand(i);
      end
      wait_idle(200);

      rr_mode  = 2;
      resReady = 1'b1;
      for (int j = 0; j < 6; j++) push_rand(j % NUM_REQ);
      n = 0;
      do begin
         @(posedge clk);
         #2;
         n++;
      end while (resValid !== 1'b1 && n < 50);
      chk("bp_first_result", 64'(resValid), 64'd1);
      resReady = 1'b0;
      repeat (3) @(posedge clk);
      #2 resReady = 1'b1;
      wait_idle(100);
      rr_mode = 0;

      for (int k = 1; k <= 8; k++) push(1, k, 1, 1'b0);
      wait_idle(100);

      rr_mode = 1;
      repeat (200) begin
         @(posedge clk);
         #2;
         for (int i = 0; i < NUM_REQ; i++) begin
            if ($urandom_range(0, 3) == 0) push_rand(i);
         end
      end
      wait_idle(2000);
      rr_mode = 0;

      for (int j = 0; j < 3; j++) push_rand(3);
      n = 0;
      while ((op_q[3].size() != 0 || reqValid[3]) && n < 50) begin
         @(posedge clk);
         #2;
         n++;
      end
      chk("midflight_issued", 64'(reqValid[3]), 64'd0);
      repeat (2) @(posedge clk);
      #2 reset = 1'b1;
      @(posedge clk);
      #2 reset = 1'b0;
      repeat (6) @(posedge clk);
      #2;
      push(0, 5, 7, 1'b0);
      push(1, 9, 4, 1'b1);
      wait_idle(100);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
